fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. Owns the PC and drives the instruction-cache read port. Reports fetch completion to the hazard detection unit (`inst_resp_dp`) and presents the `{pc, instruction}` pair to the IF/ID register. Obeys the hazard unit's `load_pc` and applies taken-branch and jump redirects from EX. If a redirect is accepted while a cache miss is outstanding, the stale instruction is dropped safely.

---
 rtl/rv32i_types.sv | 11 +
 rtl/fetch_unit_sat_counter.sv | 29 ++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared type definitions for the RV32I core.
package rv32i_types;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache read port and
// drops the in-flight instruction when a redirect lands during a miss.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        inst_resp_dp,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] fetch_count,
    output logic [31:0] miss_cycles
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;
    logic         take_redirect;

    // A redirect only counts when the hazard unit lets the PC move.
    assign take_redirect = load_pc && redirect;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        unique case (state_q)
            RUN: begin
                if (imem_resp) begin
                    if (take_redirect) begin
                        pc_d = redirect_target;
                    end else if (load_pc) begin
                        pc_d = pc_q + INST_BYTES;
                    end
                end else if (take_redirect) begin
                    // Keep the address stable until the miss completes.
                    pending_pc_d = redirect_target;
                    state_d      = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_resp) begin
                    pc_d    = take_redirect ? redirect_target : pending_pc_q;
                    state_d = RUN;
                end else if (take_redirect) begin
                    pending_pc_d = redirect_target;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    assign imem_read    = !rst;
    assign imem_address = rst ? RESET_PC : pc_q;
    assign inst_resp_dp = imem_resp && (state_q == RUN) && !rst;
    assign if_pc        = pc_q;
    assign if_inst      = imem_rdata;

    sat_counter u_fetch_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (inst_resp_dp && load_pc),
        .count (fetch_count)
    );

    sat_counter u_miss_cycles (
        .clk   (clk),
        .rst   (rst),
        .inc   (imem_read && !imem_resp),
        .count (miss_cycles)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit with a queue-based scoreboard of per-cycle expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_pc = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        inst_resp_dp;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] fetch_count;
    logic [31:0] miss_cycles;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_pc         (load_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_read       (imem_read),
        .imem_rdata      (imem_rdata),
        .imem_resp       (imem_resp),
        .inst_resp_dp    (inst_resp_dp),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .fetch_count     (fetch_count),
        .miss_cycles     (miss_cycles)
    );

    typedef struct {
        logic        r;
        logic        ld;
        logic        rd;
        logic [31:0] tgt;
        logic        rsp;
        logic [31:0] ea;
        logic        edp;
        int          efc;
        int          emc;
    } stim_t;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        dp;
        logic [31:0] inst;
        int          fc;
        int          mc;
    } exp_t;

    exp_t  sb[$];
    stim_t st[$];
    int    checks = 0;
    int    errors = 0;

    // Apply one cycle of stimulus after the falling edge and queue what the DUT must show.
    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst             = s.r;
        load_pc         = s.ld;
        redirect        = s.rd;
        redirect_target = s.tgt;
        imem_resp       = s.rsp;
        imem_rdata      = $urandom;
        e.addr = s.ea;
        e.rd   = !s.r;
        e.dp   = s.edp;
        e.inst = imem_rdata;
        e.fc   = s.efc;
        e.mc   = s.emc;
        sb.push_back(e);
        #2;
    endtask

    task automatic test_reset();
        exp_t e;
        st.delete();
        st.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 0, 0});
        st.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h60, 1'b0, 0, 0});
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++; if (imem_address !== e.addr) begin errors++; $display("FAIL reset addr[%0d] got %h want %h", i, imem_address, e.addr); end
            checks++; if (imem_read !== e.rd) begin errors++; $display("FAIL reset read[%0d] got %b want %b", i, imem_read, e.rd); end
            checks++; if (inst_resp_dp !== e.dp) begin errors++; $display("FAIL reset dp[%0d] got %b want %b", i, inst_resp_dp, e.dp); end
            checks++; if (fetch_count !== 32'(e.fc)) begin errors++; $display("FAIL reset fetch_count[%0d] got %0d want %0d", i, fetch_count, e.fc); end
            checks++; if (miss_cycles !== 32'(e.mc)) begin errors++; $display("FAIL reset miss_cycles[%0d] got %0d want %0d", i, miss_cycles, e.mc); end
        end
    endtask

    task automatic test_seq_hits();
        exp_t e;
        st.delete();
        for (int k = 0; k < 4; k++) begin
            st.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h60 + 32'(4 * k), 1'b1, k, 0});
        end
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++; if (imem_address !== e.addr) begin errors++; $display("FAIL seq addr[%0d] got %h want %h", i, imem_address, e.addr); end
            checks++; if (imem_read !== e.rd) begin errors++; $display("FAIL seq read[%0d] got %b want %b", i, imem_read, e.rd); end
            checks++; if (inst_resp_dp !== e.dp) begin errors++; $display("FAIL seq dp[%0d] got %b want %b", i, inst_resp_dp, e.dp); end
            checks++; if (if_pc !== e.addr) begin errors++; $display("FAIL seq if_pc[%0d] got %h want %h", i, if_pc, e.addr); end
            checks++; if (if_inst !== e.inst) begin errors++; $display("FAIL seq if_inst[%0d] got %h want %h", i, if_inst, e.inst); end
            checks++; if (fetch_count !== 32'(e.fc)) begin errors++; $display("FAIL seq fetch_count[%0d] got %0d want %0d", i, fetch_count, e.fc); end
        end
    endtask

    task automatic test_stall_and_redirect_hit();
        exp_t e;
        st.delete();
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h80,  1'b1, 32'h70,  1'b1, 4, 0});
        st.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 5, 0});
        st.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 5, 0});
        st.push_back('{1'b0, 1'b0, 1'b1, 32'h998, 1'b1, 32'h80,  1'b1, 5, 0});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b1, 5, 0});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 6, 0});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 7, 0});
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++; if (imem_address !== e.addr) begin errors++; $display("FAIL stall addr[%0d] got %h want %h", i, imem_address, e.addr); end
            checks++; if (inst_resp_dp !== e.dp) begin errors++; $display("FAIL stall dp[%0d] got %b want %b", i, inst_resp_dp, e.dp); end
            checks++; if (fetch_count !== 32'(e.fc)) begin errors++; $display("FAIL stall fetch_count[%0d] got %0d want %0d", i, fetch_count, e.fc); end
        end
    endtask

    task automatic test_redirect_miss();
        exp_t e;
        st.delete();
        st.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 8, 0});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h104, 1'b0, 8, 1});
        st.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 8, 2});
        st.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 8, 3});
        st.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 8, 4});
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++; if (imem_address !== e.addr) begin errors++; $display("FAIL miss addr[%0d] got %h want %h", i, imem_address, e.addr); end
            checks++; if (inst_resp_dp !== e.dp) begin errors++; $display("FAIL miss dp[%0d] got %b want %b", i, inst_resp_dp, e.dp); end
            checks++; if (fetch_count !== 32'(e.fc)) begin errors++; $display("FAIL miss fetch_count[%0d] got %0d want %0d", i, fetch_count, e.fc); end
            checks++; if (miss_cycles !== 32'(e.mc)) begin errors++; $display("FAIL miss miss_cycles[%0d] got %0d want %0d", i, miss_cycles, e.mc); end
        end
    endtask

    task automatic test_double_redirect();
        exp_t e;
        st.delete();
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h300, 1'b0, 8, 4});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h300, 1'b0, 8, 5});
        st.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 8, 6});
        st.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h500, 1'b1, 8, 6});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 32'h504, 1'b0, 9, 6});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h504, 1'b0, 9, 7});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h700, 1'b1, 9, 7});
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++; if (imem_address !== e.addr) begin errors++; $display("FAIL dbl addr[%0d] got %h want %h", i, imem_address, e.addr); end
            checks++; if (inst_resp_dp !== e.dp) begin errors++; $display("FAIL dbl dp[%0d] got %b want %b", i, inst_resp_dp, e.dp); end
            checks++; if (fetch_count !== 32'(e.fc)) begin errors++; $display("FAIL dbl fetch_count[%0d] got %0d want %0d", i, fetch_count, e.fc); end
            checks++; if (miss_cycles !== 32'(e.mc)) begin errors++; $display("FAIL dbl miss_cycles[%0d] got %0d want %0d", i, miss_cycles, e.mc); end
        end
    endtask

    task automatic test_wrap_and_reset();
        exp_t e;
        st.delete();
        st.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 1'b1, 10, 7});
        st.push_back('{1'b0, 1'b1, 1'b1, 32'h800, 1'b0, 32'h0,         1'b0, 11, 7});
        st.push_back('{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h60,        1'b0, 11, 8});
        st.push_back('{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h60,        1'b1, 0,  0});
        st.push_back('{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h64,        1'b1, 1,  0});
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            checks++; if (imem_address !== e.addr) begin errors++; $display("FAIL wrap addr[%0d] got %h want %h", i, imem_address, e.addr); end
            checks++; if (imem_read !== e.rd) begin errors++; $display("FAIL wrap read[%0d] got %b want %b", i, imem_read, e.rd); end
            checks++; if (inst_resp_dp !== e.dp) begin errors++; $display("FAIL wrap dp[%0d] got %b want %b", i, inst_resp_dp, e.dp); end
            checks++; if (fetch_count !== 32'(e.fc)) begin errors++; $display("FAIL wrap fetch_count[%0d] got %0d want %0d", i, fetch_count, e.fc); end
            checks++; if (miss_cycles !== 32'(e.mc)) begin errors++; $display("FAIL wrap miss_cycles[%0d] got %0d want %0d", i, miss_cycles, e.mc); end
        end
    endtask

    initial begin
        test_reset();
        test_seq_hits();
        test_stall_and_redirect_hit();
        test_redirect_miss();
        test_double_redirect();
        test_wrap_and_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
